// File: rtl/cache_refill_if.sv
// Shared cache geometry package and the refill engine's bus interface.
// Optional statistics ports exist only when CACHE_REFILL_STATS_EN is defined.
package cache_pkg;
    localparam int SetWidth      = 4;
    localparam int TagWidth      = 8;
    localparam int DataWidth     = 32;
    localparam int Associativity = 2;
    localparam int WayWidth      = (Associativity > 1) ? $clog2(Associativity) : 1;
    localparam int NumSets       = 1 << SetWidth;

    typedef struct packed {
        logic                valid;
        logic [TagWidth-1:0] tag;
    } block_info_t;

    typedef logic [DataWidth-1:0] block_data_t;
endpackage

interface cache_refill_if;
    import cache_pkg::*;

    logic                         miss_valid_i;
    logic                         miss_ready_o;
    logic [SetWidth-1:0]          miss_set_i;
    logic [TagWidth-1:0]          miss_tag_i;
    logic                         mem_req_valid_o;
    logic                         mem_req_ready_i;
    logic [TagWidth+SetWidth-1:0] mem_req_addr_o;
    logic                         mem_resp_valid_i;
    block_data_t                  mem_resp_data_i;
    logic                         write_en_o;
    logic [SetWidth-1:0]          write_set_o;
    block_info_t                  write_info_o [Associativity];
    logic [WayWidth-1:0]          write_data_way_o;
    block_data_t                  write_data_o;
    logic                         refill_done_o;
`ifdef CACHE_REFILL_STATS_EN
    logic [31:0]                  miss_count_o;
    logic [31:0]                  evict_count_o;
`endif

    modport master (
`ifdef CACHE_REFILL_STATS_EN
        output miss_count_o, evict_count_o,
`endif
        input  miss_valid_i, miss_set_i, miss_tag_i,
        input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        output miss_ready_o, mem_req_valid_o, mem_req_addr_o,
        output write_en_o, write_set_o, write_info_o,
        output write_data_way_o, write_data_o, refill_done_o
    );

    modport slave (
`ifdef CACHE_REFILL_STATS_EN
        input  miss_count_o, evict_count_o,
`endif
        output miss_valid_i, miss_set_i, miss_tag_i,
        output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        input  miss_ready_o, mem_req_valid_o, mem_req_addr_o,
        input  write_en_o, write_set_o, write_info_o,
        input  write_data_way_o, write_data_o, refill_done_o
    );
endinterface

// File: rtl/cache_refill.sv
// Cache miss/fill engine: fetches a block, picks a victim, writes a full line.
// Define CACHE_REFILL_STATS_EN to add saturating miss/evict counters.
module cache_refill
    import cache_pkg::*;
#(
    parameter bit FillInvalidFirst = 1'b1
) (
    input logic            clk_i,
    input logic            rst_i,
    cache_refill_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    state_t              state;
    logic [SetWidth-1:0] set_q;
    logic [TagWidth-1:0] tag_q;
    logic                use_rr_q;
    logic                evict_q;
    block_info_t         mirror [NumSets][Associativity];
    logic [WayWidth-1:0] rr [NumSets];

    block_info_t         line     [Associativity];
    block_info_t         new_line [Associativity];
    logic                hit;
    logic                inv;
    logic [WayWidth-1:0] hit_way;
    logic [WayWidth-1:0] inv_way;
    logic [WayWidth-1:0] victim;
    logic                use_rr;
    logic                victim_valid;
    logic [WayWidth-1:0] rr_next;

    // Victim choice: matching tag, then lowest invalid way, then round-robin.
    always_comb begin
        hit          = 1'b0;
        inv          = 1'b0;
        hit_way      = '0;
        inv_way      = '0;
        victim_valid = 1'b0;
        for (int i = 0; i < Associativity; i++) begin
            line[i] = mirror[set_q][i];
            if (!hit && line[i].valid && line[i].tag == tag_q) begin
                hit     = 1'b1;
                hit_way = WayWidth'(i);
            end
            if (!inv && !line[i].valid) begin
                inv     = 1'b1;
                inv_way = WayWidth'(i);
            end
        end
        use_rr = !hit && !(FillInvalidFirst && inv);
        victim = hit ? hit_way : (use_rr ? rr[set_q] : inv_way);
        for (int i = 0; i < Associativity; i++) begin
            new_line[i] = line[i];
            if (victim == WayWidth'(i)) begin
                new_line[i]  = '{valid: 1'b1, tag: tag_q};
                victim_valid = line[i].valid;
            end
        end
        rr_next = (rr[set_q] == WayWidth'(Associativity - 1))
                ? '0 : rr[set_q] + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                <= IDLE;
            set_q                <= '0;
            tag_q                <= '0;
            use_rr_q             <= 1'b0;
            evict_q              <= 1'b0;
            bus.miss_ready_o     <= 1'b1;
            bus.mem_req_valid_o  <= 1'b0;
            bus.mem_req_addr_o   <= '0;
            bus.write_en_o       <= 1'b0;
            bus.refill_done_o    <= 1'b0;
            bus.write_set_o      <= '0;
            bus.write_data_way_o <= '0;
            bus.write_data_o     <= '0;
            for (int i = 0; i < Associativity; i++) begin
                bus.write_info_o[i] <= '0;
            end
            for (int s = 0; s < NumSets; s++) begin
                rr[s] <= '0;
                for (int i = 0; i < Associativity; i++) begin
                    mirror[s][i] <= '0;
                end
            end
        end else begin
            bus.write_en_o    <= 1'b0;
            bus.refill_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.miss_valid_i && bus.miss_ready_o) begin
                        set_q               <= bus.miss_set_i;
                        tag_q               <= bus.miss_tag_i;
                        bus.mem_req_addr_o  <= {bus.miss_tag_i, bus.miss_set_i};
                        bus.mem_req_valid_o <= 1'b1;
                        bus.miss_ready_o    <= 1'b0;
                        state               <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready_i) begin
                        bus.mem_req_valid_o <= 1'b0;
                        state               <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid_i) begin
                        bus.write_data_o     <= bus.mem_resp_data_i;
                        bus.write_en_o       <= 1'b1;
                        bus.refill_done_o    <= 1'b1;
                        bus.write_set_o      <= set_q;
                        bus.write_data_way_o <= victim;
                        for (int i = 0; i < Associativity; i++) begin
                            bus.write_info_o[i] <= new_line[i];
                        end
                        use_rr_q <= use_rr;
                        evict_q  <= !hit && victim_valid;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    for (int i = 0; i < Associativity; i++) begin
                        mirror[set_q][i] <= bus.write_info_o[i];
                    end
                    if (use_rr_q) begin
                        rr[set_q] <= rr_next;
                    end
                    bus.miss_ready_o <= 1'b1;
                    state            <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_REFILL_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.miss_count_o  <= '0;
            bus.evict_count_o <= '0;
        end else begin
            if (state == IDLE && bus.miss_valid_i && bus.miss_ready_o
                && bus.miss_count_o != 32'hFFFF_FFFF) begin
                bus.miss_count_o <= bus.miss_count_o + 32'd1;
            end
            if (state == WRITE && evict_q
                && bus.evict_count_o != 32'hFFFF_FFFF) begin
                bus.evict_count_o <= bus.evict_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: latency, victim choice, stalls, resets.
// Assumes the package geometry of 2 ways and 4-bit sets.
module tb_cache_refill;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   hs = 0;
    int   hs0;

    cache_refill_if bus ();

    cache_refill dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_req_valid_o && bus.mem_req_ready_i) hs++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic send_miss(input logic [3:0] s, input logic [7:0] t);
        bus.miss_valid_i = 1'b1;
        bus.miss_set_i   = s;
        bus.miss_tag_i   = t;
        step();
        bus.miss_valid_i = 1'b0;
    endtask

    task automatic refill(input logic [3:0] s, input logic [7:0] t,
                          input logic [31:0] d);
        send_miss(s, t);
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = d;
        step();
        bus.mem_resp_valid_i = 1'b0;
    endtask

    initial begin
        bus.miss_valid_i     = 1'b0;
        bus.miss_set_i       = '0;
        bus.miss_tag_i       = '0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_data_i  = '0;
        repeat (2) step();

        chk("rst_miss_ready", 64'(bus.miss_ready_o), 64'd1);
        chk("rst_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        chk("rst_write_en", 64'(bus.write_en_o), 64'd0);
        chk("rst_done", 64'(bus.refill_done_o), 64'd0);
        chk("rst_addr", 64'(bus.mem_req_addr_o), 64'd0);
        chk("rst_data", 64'(bus.write_data_o), 64'd0);
        chk("rst_info0", 64'(bus.write_info_o[0]), 64'd0);
`ifdef CACHE_REFILL_STATS_EN
        chk("rst_miss_cnt", 64'(bus.miss_count_o), 64'd0);
        chk("rst_evict_cnt", 64'(bus.evict_count_o), 64'd0);
`endif
        rst = 1'b0;
        step();

        // basic latency: accept T, req T+1, resp T+2, write T+3
        send_miss(4'd3, 8'h12);
        chk("t1_ready_busy", 64'(bus.miss_ready_o), 64'd0);
        chk("t1_req_valid", 64'(bus.mem_req_valid_o), 64'd1);
        chk("t1_addr", 64'(bus.mem_req_addr_o), 64'h123);
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        chk("t1_req_drop", 64'(bus.mem_req_valid_o), 64'd0);
        chk("t1_no_early_wr", 64'(bus.write_en_o), 64'd0);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = 32'hA5;
        step();
        bus.mem_resp_valid_i = 1'b0;
        chk("t1_write_en", 64'(bus.write_en_o), 64'd1);
        chk("t1_done", 64'(bus.refill_done_o), 64'd1);
        chk("t1_set", 64'(bus.write_set_o), 64'd3);
        chk("t1_way", 64'(bus.write_data_way_o), 64'd0);
        chk("t1_info0", 64'(bus.write_info_o[0]), 64'h112);
        chk("t1_info1", 64'(bus.write_info_o[1]), 64'h000);
        chk("t1_data", 64'(bus.write_data_o), 64'hA5);
        step();
        chk("t1_write_end", 64'(bus.write_en_o), 64'd0);
        chk("t1_done_end", 64'(bus.refill_done_o), 64'd0);
        chk("t1_ready_back", 64'(bus.miss_ready_o), 64'd1);

        // fill order in set 5: invalid ways first, then round-robin
        refill(4'd5, 8'h01, 32'h11);
        chk("t2a_way", 64'(bus.write_data_way_o), 64'd0);
        step();
        refill(4'd5, 8'h02, 32'h22);
        chk("t2b_way", 64'(bus.write_data_way_o), 64'd1);
        chk("t2b_info0", 64'(bus.write_info_o[0]), 64'h101);
        step();
        refill(4'd5, 8'h03, 32'h33);
        chk("t2c_way", 64'(bus.write_data_way_o), 64'd0);
        chk("t2c_info0", 64'(bus.write_info_o[0]), 64'h103);
        chk("t2c_info1", 64'(bus.write_info_o[1]), 64'h102);
        step();

        // request stalled four cycles
        hs0 = hs;
        send_miss(4'd7, 8'h44);
        for (int i = 0; i < 4; i++) begin
            chk("t3_stall_valid", 64'(bus.mem_req_valid_o), 64'd1);
            chk("t3_stall_addr", 64'(bus.mem_req_addr_o), 64'h447);
            step();
        end
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        chk("t3_valid_drop", 64'(bus.mem_req_valid_o), 64'd0);
        chk("t3_handshakes", 64'(hs - hs0), 64'd1);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = 32'h77;
        step();
        bus.mem_resp_valid_i = 1'b0;
        chk("t3_write_en", 64'(bus.write_en_o), 64'd1);
        chk("t3_data", 64'(bus.write_data_o), 64'h77);
        step();

        // stray responses in IDLE and in the REQ handshake cycle
        bus.miss_valid_i     = 1'b1;
        bus.miss_set_i       = 4'd9;
        bus.miss_tag_i       = 8'h20;
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = 32'hFF;
        step();
        bus.miss_valid_i    = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        chk("t4_no_wr_a", 64'(bus.write_en_o), 64'd0);
        step();
        chk("t4_no_wr_b", 64'(bus.write_en_o), 64'd0);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = 32'h3C;
        step();
        bus.mem_resp_valid_i = 1'b0;
        chk("t4_write_en", 64'(bus.write_en_o), 64'd1);
        chk("t4_data", 64'(bus.write_data_o), 64'h3C);
        step();

        // tag already in way 1: reuse it, round-robin pointer untouched
        refill(4'd5, 8'h02, 32'h55);
        chk("t5_hit_way", 64'(bus.write_data_way_o), 64'd1);
        chk("t5_info0", 64'(bus.write_info_o[0]), 64'h103);
        chk("t5_info1", 64'(bus.write_info_o[1]), 64'h102);
        step();
        refill(4'd5, 8'h04, 32'h66);
        chk("t5_rr_way", 64'(bus.write_data_way_o), 64'd1);
        chk("t5_rr_info1", 64'(bus.write_info_o[1]), 64'h104);
        step();

        // reset while waiting for memory
        send_miss(4'd5, 8'h09);
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_wr", 64'(bus.write_en_o), 64'd0);
        chk("t6_rst_ready", 64'(bus.miss_ready_o), 64'd1);
        chk("t6_rst_req", 64'(bus.mem_req_valid_o), 64'd0);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = 32'h99;
        step();
        rst = 1'b0;
        step();
        bus.mem_resp_valid_i = 1'b0;
        chk("t6_no_wr_a", 64'(bus.write_en_o), 64'd0);
`ifdef CACHE_REFILL_STATS_EN
        chk("t6_miss_cnt", 64'(bus.miss_count_o), 64'd0);
        chk("t6_evict_cnt", 64'(bus.evict_count_o), 64'd0);
`endif
        step();
        chk("t6_no_wr_b", 64'(bus.write_en_o), 64'd0);
        refill(4'd5, 8'h0B, 32'hBB);
        chk("t6_way", 64'(bus.write_data_way_o), 64'd0);
        chk("t6_info0", 64'(bus.write_info_o[0]), 64'h10B);
        chk("t6_info1", 64'(bus.write_info_o[1]), 64'h000);
        chk("t6_data", 64'(bus.write_data_o), 64'hBB);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
